// File: rtl/dmem_responder.sv
// Data-memory responder for the core's single-port dmem interface: word RAM plus an
// MMIO window with a 64-bit cycle counter, a tohost completion register and a console FIFO.
module dmem_responder #(
    parameter int AddressWidth  = 30,
    parameter int DataWidth     = 32,
    parameter int RamDepthLog2  = 12,
    parameter int FifoDepthLog2 = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddressWidth-1:0] dmem_address0,
    input  logic                    dmem_ce0,
    input  logic                    dmem_we0,
    input  logic [DataWidth-1:0]    dmem_d0,
    output logic [DataWidth-1:0]    dmem_q0,
    output logic                    con_valid,
    input  logic                    con_ready,
    output logic [7:0]              con_data,
    output logic                    done,
    output logic [31:0]             exit_code
);

    localparam int FifoDepth = 1 << FifoDepthLog2;

    typedef enum logic [2:0] {
        RegCycleLo = 3'd0,
        RegCycleHi = 3'd1,
        RegTohost  = 3'd2,
        RegConsole = 3'd3
    } mmioReg_e;

    logic [DataWidth-1:0]    ram [2**RamDepthLog2];
    logic [7:0]              fifoMem [FifoDepth];

    logic [DataWidth-1:0]    ramQ;
    logic [DataWidth-1:0]    mmioQ;
    logic [DataWidth-1:0]    mmioRdata;
    logic                    selMmio;
    logic [63:0]             cycleCount;
    logic [31:0]             hiSnap;
    logic                    overflow;
    logic [FifoDepthLog2-1:0] rdPtr;
    logic [FifoDepthLog2-1:0] wrPtr;
    logic [FifoDepthLog2:0]  fifoCount;

    logic                    isMmio;
    logic [RamDepthLog2-1:0] ramIndex;
    logic [2:0]              regIndex;
    logic                    ramAccess;
    logic                    mmioAccess;
    logic                    push;
    logic                    pop;
    logic                    fifoFull;
    logic                    pushAccept;
    logic                    tohostWrite;
    logic                    unusedAddrBits;

    assign isMmio      = dmem_address0[AddressWidth-1];
    assign ramIndex    = dmem_address0[RamDepthLog2-1:0];
    assign regIndex    = dmem_address0[2:0];
    assign ramAccess   = dmem_ce0 & ~isMmio;
    assign mmioAccess  = dmem_ce0 & isMmio;
    assign tohostWrite = mmioAccess & dmem_we0 & (regIndex == RegTohost);
    assign push        = mmioAccess & dmem_we0 & (regIndex == RegConsole);
    assign pop         = con_valid & con_ready;
    assign fifoFull    = (fifoCount == (FifoDepthLog2 + 1)'(FifoDepth));
    assign pushAccept  = push & (~fifoFull | pop);

    // Upper RAM address bits alias by design.
    assign unusedAddrBits = ^dmem_address0[AddressWidth-2:RamDepthLog2];

    assign con_valid = (fifoCount != '0);
    assign con_data  = con_valid ? fifoMem[rdPtr] : 8'h00;
    // Both read paths hold their value while idle, so the registered select alone keeps dmem_q0 stable.
    assign dmem_q0   = selMmio ? mmioQ : ramQ;

    // NOTE: every variable written in always_comb gets a default first, otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        mmioRdata = '0;
        case (regIndex)
            RegCycleLo: mmioRdata = DataWidth'(cycleCount[31:0]);
            RegCycleHi: mmioRdata = DataWidth'(hiSnap);
            RegTohost:  mmioRdata = DataWidth'(done);
            RegConsole: mmioRdata = DataWidth'({overflow, 23'b0, 8'(fifoCount)});
            default:    mmioRdata = '0;
        endcase
    end

    // NOTE: storage arrays carry no reset so they map onto block RAM; only the
    // control state around them is reset.
    always_ff @(posedge clk) begin
        if (ramAccess) begin
            ramQ <= ram[ramIndex];
            if (dmem_we0) ram[ramIndex] <= dmem_d0;
        end
        if (pushAccept) fifoMem[wrPtr] <= dmem_d0[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what makes reads return old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCount <= '0;
            hiSnap     <= '0;
            mmioQ      <= '0;
            selMmio    <= 1'b1;
            done       <= 1'b0;
            exit_code  <= '0;
            overflow   <= 1'b0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            fifoCount  <= '0;
        end else begin
            cycleCount <= cycleCount + 64'd1;
            if (dmem_ce0) selMmio <= isMmio;
            if (mmioAccess) begin
                mmioQ <= mmioRdata;
                if (regIndex == RegCycleLo) hiSnap <= cycleCount[63:32];
            end
            if (tohostWrite && !done) begin
                done      <= 1'b1;
                exit_code <= 32'(dmem_d0);
            end
            if (pop) rdPtr <= rdPtr + 1'b1;
            if (pushAccept) wrPtr <= wrPtr + 1'b1;
            else if (push) overflow <= 1'b1;
            case ({pushAccept, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized RAM and
// console traffic compared against a queue/array reference model.
module tb_dmem_responder;

    localparam logic [29:0] MmioBase = 30'h2000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] dmem_address0 = '0;
    logic        dmem_ce0 = 1'b0;
    logic        dmem_we0 = 1'b0;
    logic [31:0] dmem_d0 = '0;
    logic [31:0] dmem_q0;
    logic        con_valid;
    logic        con_ready = 1'b0;
    logic [7:0]  con_data;
    logic        done;
    logic [31:0] exit_code;

    int total = 0;
    int bad = 0;

    longint unsigned edgeCount = 0;
    longint unsigned cntBase = 0;
    longint unsigned cntOffset = 0;

    dmem_responder dut (
        .clk(clk), .rst(rst),
        .dmem_address0(dmem_address0), .dmem_ce0(dmem_ce0), .dmem_we0(dmem_we0),
        .dmem_d0(dmem_d0), .dmem_q0(dmem_q0),
        .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
        .done(done), .exit_code(exit_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Counter value the DUT holds between edges, from elapsed edges since the last anchor.
    function automatic longint unsigned expCounter();
        return cntOffset + (edgeCount - cntBase);
    endfunction

    task automatic op(input logic [29:0] addr, input logic we, input logic [31:0] d);
        dmem_address0 = addr;
        dmem_ce0 = 1'b1;
        dmem_we0 = we;
        dmem_d0 = d;
        @(posedge clk);
        #1;
        dmem_ce0 = 1'b0;
        dmem_we0 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        #2;
        rst = 1'b1;
        con_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cntBase = edgeCount;
        cntOffset = 0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (dmem_q0 !== 32'h0) begin bad++; $display("FAIL reset_q0 got=%h want=0", dmem_q0); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (exit_code !== 32'h0) begin bad++; $display("FAIL reset_exit got=%h want=0", exit_code); end
        total++; if (con_valid !== 1'b0) begin bad++; $display("FAIL reset_con_valid got=%b want=0", con_valid); end
        total++; if (con_data !== 8'h00) begin bad++; $display("FAIL reset_con_data got=%h want=00", con_data); end
        doReset();
    endtask

    task automatic test_ram();
        logic [31:0] model [int];
        logic [31:0] last;
        op(30'd5, 1'b1, 32'hDEAD_BEEF);
        op(30'd5, 1'b0, 32'h0);
        total++; if (dmem_q0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_read got=%h want=deadbeef", dmem_q0); end
        op(30'd5 + 30'd4096, 1'b0, 32'h0);
        total++; if (dmem_q0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_alias got=%h want=deadbeef", dmem_q0); end
        idle(3);
        total++; if (dmem_q0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_hold got=%h want=deadbeef", dmem_q0); end
        op(30'd7, 1'b1, 32'h1);
        op(30'd7, 1'b1, 32'h2);
        total++; if (dmem_q0 !== 32'h1) begin bad++; $display("FAIL ram_read_first got=%h want=1", dmem_q0); end
        op(30'd7, 1'b0, 32'h0);
        total++; if (dmem_q0 !== 32'h2) begin bad++; $display("FAIL ram_after_write got=%h want=2", dmem_q0); end
        model[5] = 32'hDEAD_BEEF;
        model[7] = 32'h2;
        for (int i = 0; i < 150; i++) begin
            int idx;
            logic we;
            logic [31:0] d;
            idx = $urandom_range(0, 15);
            we = 1'($urandom_range(0, 1));
            d = $urandom;
            op({1'b0, 17'($urandom), 12'(idx)}, we, d);
            if (model.exists(idx)) begin
                last = model[idx];
                total++;
                if (dmem_q0 !== last) begin bad++; $display("FAIL ram_random idx=%0d got=%h want=%h", idx, dmem_q0, last); end
            end
            if (we) model[idx] = d;
        end
    endtask

    task automatic test_cycle();
        longint unsigned e;
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(1, 20));
            e = expCounter();
            op(MmioBase | 30'd0, 1'b0, 32'h0);
            total++; if (dmem_q0 !== e[31:0]) begin bad++; $display("FAIL cycle_lo got=%h want=%h", dmem_q0, e[31:0]); end
        end
        dut.cycleCount = 64'h0000_0000_FFFF_FFFF;
        cntOffset = 64'h0000_0000_FFFF_FFFF;
        cntBase = edgeCount;
        op(MmioBase | 30'd0, 1'b0, 32'h0);
        total++; if (dmem_q0 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cycle_lo_forced got=%h want=ffffffff", dmem_q0); end
        idle(1);
        op(MmioBase | 30'd1, 1'b0, 32'h0);
        total++; if (dmem_q0 !== 32'h0) begin bad++; $display("FAIL cycle_hi_snap got=%h want=0", dmem_q0); end
        e = expCounter();
        op(MmioBase | 30'd0, 1'b0, 32'h0);
        total++; if (dmem_q0 !== e[31:0]) begin bad++; $display("FAIL cycle_lo_wrap got=%h want=%h", dmem_q0, e[31:0]); end
        op(MmioBase | 30'd1, 1'b0, 32'h0);
        total++; if (dmem_q0 !== e[63:32]) begin bad++; $display("FAIL cycle_hi_wrap got=%h want=%h", dmem_q0, e[63:32]); end
    endtask

    task automatic test_console();
        logic [7:0] want;
        doReset();
        for (int i = 0; i < 5; i++) op(MmioBase | 30'd3, 1'b1, 32'(8'h41 + i));
        op(MmioBase | 30'd3, 1'b0, 32'h0);
        total++; if (dmem_q0 !== 32'h8000_0004) begin bad++; $display("FAIL con_status got=%h want=80000004", dmem_q0); end
        total++; if (con_data !== 8'h41 || con_valid !== 1'b1) begin bad++; $display("FAIL con_head got=%h/%b want=41/1", con_data, con_valid); end
        con_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            want = 8'h41 + 8'(i);
            total++; if (con_data !== want || con_valid !== 1'b1) begin bad++; $display("FAIL con_drain got=%h want=%h", con_data, want); end
            idle(1);
        end
        total++; if (con_valid !== 1'b0 || con_data !== 8'h00) begin bad++; $display("FAIL con_empty got=%b/%h want=0/00", con_valid, con_data); end
        con_ready = 1'b0;
    endtask

    task automatic test_full_pushpop();
        logic [7:0] exp [4] = '{8'h58, 8'h59, 8'h5A, 8'h51};
        doReset();
        op(MmioBase | 30'd3, 1'b1, 32'h57);
        op(MmioBase | 30'd3, 1'b1, 32'h58);
        op(MmioBase | 30'd3, 1'b1, 32'h59);
        op(MmioBase | 30'd3, 1'b1, 32'h5A);
        con_ready = 1'b1;
        op(MmioBase | 30'd3, 1'b1, 32'h51);
        con_ready = 1'b0;
        op(MmioBase | 30'd3, 1'b0, 32'h0);
        total++; if (dmem_q0 !== 32'h0000_0004) begin bad++; $display("FAIL full_pushpop_status got=%h want=00000004", dmem_q0); end
        con_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (con_data !== exp[i]) begin bad++; $display("FAIL full_pushpop_order got=%h want=%h", con_data, exp[i]); end
            idle(1);
        end
        con_ready = 1'b0;
    endtask

    task automatic test_console_random();
        logic [7:0] q[$];
        logic ovf = 1'b0;
        doReset();
        for (int i = 0; i < 150; i++) begin
            int r;
            logic [7:0] b;
            logic [31:0] expStatus;
            logic popNow;
            logic acc;
            logic [7:0] head;
            r = $urandom_range(0, 2);
            b = 8'($urandom);
            con_ready = 1'($urandom_range(0, 1));
            expStatus = {ovf, 23'b0, 8'(q.size())};
            popNow = (q.size() > 0) && con_ready;
            acc = (r == 0) && (q.size() < 4 || popNow);
            if (r == 0) op(MmioBase | 30'd3, 1'b1, {24'hABCDEF, b});
            else if (r == 1) op(MmioBase | 30'd3, 1'b0, 32'h0);
            else idle(1);
            if (popNow) void'(q.pop_front());
            if (acc) q.push_back(b);
            else if (r == 0) ovf = 1'b1;
            head = (q.size() > 0) ? q[0] : 8'h00;
            total++; if (con_valid !== (q.size() > 0) || con_data !== head) begin
                bad++; $display("FAIL con_random_head got=%b/%h want=%b/%h", con_valid, con_data, q.size() > 0, head);
            end
            if (r == 1) begin
                total++; if (dmem_q0 !== expStatus) begin bad++; $display("FAIL con_random_status got=%h want=%h", dmem_q0, expStatus); end
            end
        end
        con_ready = 1'b0;
    endtask

    task automatic test_tohost();
        doReset();
        op(MmioBase | 30'd2, 1'b1, 32'h2A);
        total++; if (dmem_q0 !== 32'h0) begin bad++; $display("FAIL tohost_old got=%h want=0", dmem_q0); end
        total++; if (done !== 1'b1 || exit_code !== 32'h2A) begin bad++; $display("FAIL tohost_first got=%b/%h want=1/2a", done, exit_code); end
        op(MmioBase | 30'd2, 1'b1, 32'h7);
        total++; if (dmem_q0 !== 32'h1) begin bad++; $display("FAIL tohost_old2 got=%h want=1", dmem_q0); end
        total++; if (exit_code !== 32'h2A) begin bad++; $display("FAIL tohost_sticky got=%h want=2a", exit_code); end
        op(MmioBase | 30'd6, 1'b1, 32'h1234_5678);
        op(MmioBase | 30'd6, 1'b0, 32'h0);
        total++; if (dmem_q0 !== 32'h0) begin bad++; $display("FAIL mmio_unused got=%h want=0", dmem_q0); end
        op(MmioBase | 30'd3, 1'b1, 32'h4B);
        total++; if (con_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", con_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (done !== 1'b0 || exit_code !== 32'h0) begin bad++; $display("FAIL async_reset_done got=%b/%h want=0/0", done, exit_code); end
        total++; if (con_valid !== 1'b0 || con_data !== 8'h00 || dmem_q0 !== 32'h0) begin
            bad++; $display("FAIL async_reset_fifo got=%b/%h/%h want=0/00/0", con_valid, con_data, dmem_q0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog elapsed=%0t want=finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_ram();
        test_cycle();
        test_console();
        test_full_pushpop();
        test_console_random();
        test_tohost();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
